// File: rtl/myvision_ram_arbiter.sv
// Arbitrates the single CPU RAM port between the Z80 bus and the cartridge loader.
// The Z80 is stalled through nWAIT while a read is in flight or the loader owns the port.
module myvision_ram_arbiter #(
    parameter logic [15:0] ROM_TOP = 16'h7FFF,
    parameter int unsigned LD_HOLD = 2
) (
    input  logic        clk_3m58,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_mreq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_wait_n,
    input  logic        ld_active,
    input  logic        ld_req,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ack,
    output logic [15:0] ram_a,
    output logic [7:0]  ram_d_o,
    input  logic [7:0]  ram_d_i,
    output logic        ram_ce_n,
    output logic        ram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_RD,
        CPU_RD_CAP,
        CPU_WR,
        LD_WR,
        LD_ACK
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  hold_reg, hold_next;
    logic        served_reg, served_next;
    logic [15:0] ram_a_reg, ram_a_next;
    logic [7:0]  ram_d_o_reg, ram_d_o_next;
    logic [7:0]  cpu_din_reg, cpu_din_next;
    logic        ram_ce_n_reg, ram_ce_n_next;
    logic        ram_we_n_reg, ram_we_n_next;
    logic        wait_n_reg, wait_n_next;
    logic        ld_ack_reg, ld_ack_next;

    logic cpu_req;
    logic cpu_unserved;
    logic cpu_rd_req;
    logic cpu_wr_req;
    logic rd_busy;
    logic ld_busy;

    // served_reg makes a request edge-qualified: one access per mreq_n low period
    assign cpu_req      = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
    assign cpu_unserved = cpu_req && !served_reg;
    assign cpu_rd_req   = cpu_unserved && !cpu_rd_n;
    assign cpu_wr_req   = cpu_unserved && cpu_rd_n;

    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        ram_a_next   = ram_a_reg;
        ram_d_o_next = ram_d_o_reg;
        cpu_din_next = cpu_din_reg;

        case (state_reg)
            IDLE: begin
                // the loader wins ties only while a download is active
                if (ld_req && (!cpu_unserved || ld_active)) begin
                    state_next   = LD_WR;
                    hold_next    = 3'(LD_HOLD - 1);
                    ram_a_next   = ld_addr;
                    ram_d_o_next = ld_data;
                end else if (cpu_rd_req && !ld_active) begin
                    state_next = CPU_RD;
                    ram_a_next = cpu_addr;
                end else if (cpu_wr_req && !ld_active) begin
                    state_next   = CPU_WR;
                    ram_a_next   = cpu_addr;
                    ram_d_o_next = cpu_dout;
                end
            end
            CPU_RD: state_next = CPU_RD_CAP;
            CPU_RD_CAP: begin
                cpu_din_next = ram_d_i;
                state_next   = IDLE;
            end
            CPU_WR: state_next = IDLE;
            LD_WR: begin
                if (hold_reg == 3'd0) begin
                    state_next = LD_ACK;
                end else begin
                    hold_next = hold_reg - 3'd1;
                end
            end
            LD_ACK:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // strobes are registered from the next state so they line up with it
        ram_ce_n_next = !((state_next == CPU_RD) || (state_next == CPU_WR) || (state_next == LD_WR));
        ram_we_n_next = !((state_next == LD_WR) ||
                          ((state_next == CPU_WR) && (ram_a_next > ROM_TOP)));
        ld_ack_next   = (state_next == LD_ACK);

        served_next = cpu_mreq_n ? 1'b0
                    : (served_reg || ((state_reg == IDLE) &&
                                      ((state_next == CPU_RD) || (state_next == CPU_WR))));

        rd_busy = (state_next == CPU_RD) || (state_next == CPU_RD_CAP) || (state_reg == CPU_RD_CAP);
        ld_busy = (state_reg == LD_WR) || (state_reg == LD_ACK) ||
                  (state_next == LD_WR) || (state_next == LD_ACK) || ld_active;
        wait_n_next = !(rd_busy || (cpu_unserved && ld_busy));
    end

    always_ff @(posedge clk_3m58) begin
        if (reset) begin
            state_reg    <= IDLE;
            hold_reg     <= 3'd0;
            served_reg   <= 1'b0;
            ram_a_reg    <= 16'h0000;
            ram_d_o_reg  <= 8'h00;
            cpu_din_reg  <= 8'hFF;
            ram_ce_n_reg <= 1'b1;
            ram_we_n_reg <= 1'b1;
            wait_n_reg   <= 1'b1;
            ld_ack_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            served_reg   <= served_next;
            ram_a_reg    <= ram_a_next;
            ram_d_o_reg  <= ram_d_o_next;
            cpu_din_reg  <= cpu_din_next;
            ram_ce_n_reg <= ram_ce_n_next;
            ram_we_n_reg <= ram_we_n_next;
            wait_n_reg   <= wait_n_next;
            ld_ack_reg   <= ld_ack_next;
        end
    end

    assign cpu_din    = cpu_din_reg;
    assign cpu_wait_n = wait_n_reg;
    assign ld_ack     = ld_ack_reg;
    assign ram_a      = ram_a_reg;
    assign ram_d_o    = ram_d_o_reg;
    assign ram_ce_n   = ram_ce_n_reg;
    assign ram_we_n   = ram_we_n_reg;

endmodule

// File: tb/tb_myvision_ram_arbiter.sv
// Bench for myvision_ram_arbiter: a reference memory model predicts every RAM access,
// a scoreboard queue holds them in service order and a negedge monitor checks the strobes.
module tb_myvision_ram_arbiter;

    localparam logic [15:0] ROM_TOP = 16'h7FFF;
    localparam int          LD_HOLD = 2;
    localparam int          TIMEOUT = 2000;

    logic        clk_3m58 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_mreq_n = 1'b1;
    logic        cpu_rd_n = 1'b1;
    logic        cpu_wr_n = 1'b1;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  cpu_din;
    logic        cpu_wait_n;
    logic        ld_active = 1'b0;
    logic        ld_req = 1'b0;
    logic [15:0] ld_addr = 16'h0000;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_ack;
    logic [15:0] ram_a;
    logic [7:0]  ram_d_o;
    logic [7:0]  ram_d_i = 8'h00;
    logic        ram_ce_n;
    logic        ram_we_n;

    int checks = 0;
    int fails = 0;
    int ack_count = 0;

    logic [7:0] ram_mem [0:65535];
    logic [7:0] ref_mem [0:65535];

    // kind: 0 = CPU read, 1 = CPU write, 2 = loader write
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
    } exp_t;
    exp_t exp_q[$];

    myvision_ram_arbiter #(.ROM_TOP(ROM_TOP), .LD_HOLD(LD_HOLD)) dut (
        .clk_3m58(clk_3m58), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_wait_n(cpu_wait_n),
        .ld_active(ld_active), .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .ram_a(ram_a), .ram_d_o(ram_d_o), .ram_d_i(ram_d_i), .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n)
    );

    always #140 clk_3m58 = ~clk_3m58;

    // external RAM: read data valid one cycle after ce_n falls
    always @(posedge clk_3m58) begin
        if (ram_ce_n === 1'b0) begin
            if (ram_we_n === 1'b0) ram_mem[ram_a] <= ram_d_o;
            ram_d_i <= ram_mem[ram_a];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void exp_rd(input logic [15:0] a);
        exp_t e;
        e.kind = 0; e.addr = a; e.data = ref_mem[a]; e.we = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_wr(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = 1; e.addr = a; e.data = d; e.we = (a > ROM_TOP);
        if (e.we) ref_mem[a] = d;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_ld(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = 2; e.addr = a; e.data = d; e.we = 1'b1;
        ref_mem[a] = d;
        exp_q.push_back(e);
    endfunction

    // monitor: pops the expected access when ce_n falls, then follows it to completion
    int   phase = 0;
    int   low_cnt = 0;
    exp_t cur;
    logic ack_prev = 1'b0;

    always @(negedge clk_3m58) begin
        if (reset) begin
            phase = 0;
            ack_prev = 1'b0;
        end else begin
            if (ld_ack && !ack_prev) ack_count++;
            ack_prev = ld_ack;
            case (phase)
                0: if (ram_ce_n == 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_strobe: ram_a=%h, no access was due", ram_a);
                        cur.kind = -1;
                    end else begin
                        cur = exp_q.pop_front();
                        check("ram_a", 32'(ram_a), 32'(cur.addr));
                        if (cur.kind != 0) check("ram_d_o", 32'(ram_d_o), 32'(cur.data));
                    end
                    low_cnt = 0;
                    phase = 1;
                end
                default: ;
            endcase
            if (phase == 1) begin
                if (ram_ce_n == 1'b0) begin
                    low_cnt++;
                    if (cur.kind >= 0) check("we_n", 32'(ram_we_n), 32'(!cur.we));
                end else begin
                    if (cur.kind >= 0) check("ce_width", 32'(low_cnt), (cur.kind == 2) ? 32'(LD_HOLD) : 32'd1);
                    if (cur.kind == 2) begin
                        check("ld_ack", 32'(ld_ack), 32'd1);
                        phase = 3;
                    end else if (cur.kind == 0) begin
                        phase = 2;
                    end else begin
                        if (cur.kind == 1) $display("txn cpu_wr addr=%h data=%h we=%0b", cur.addr, cur.data, cur.we);
                        phase = 0;
                    end
                end
            end else if (phase == 2) begin
                check("cpu_din", 32'(cpu_din), 32'(cur.data));
                $display("txn cpu_rd addr=%h data=%h", cur.addr, cpu_din);
                phase = 0;
            end else if (phase == 3) begin
                check("ld_ack_pulse", 32'(ld_ack), 32'd0);
                $display("txn ld_wr  addr=%h data=%h", cur.addr, cur.data);
                phase = 0;
            end
        end
    end

    // CPU bus cycle; caller is aligned to a negedge, the request is asserted at once
    task automatic cpu_access(input logic is_rd, input logic [15:0] a, input logic [7:0] d, input int extra);
        int n = 0;
        cpu_addr = a; cpu_dout = d; cpu_mreq_n = 1'b0;
        cpu_rd_n = !is_rd; cpu_wr_n = is_rd;
        do begin
            @(negedge clk_3m58);
            n++;
        end while (!(ram_ce_n == 1'b0 && ram_a == a && (ram_we_n == 1'b1 || !is_rd)) && n < TIMEOUT);
        if (n >= TIMEOUT) begin
            checks++; fails++;
            $display("FAIL cpu_timeout: access at %h never strobed, required within %0d cycles", a, TIMEOUT);
        end else if (is_rd) begin
            check("wait_n_rd_low", 32'(cpu_wait_n), 32'd0);
            repeat (3) @(negedge clk_3m58);
            check("wait_n_release", 32'(cpu_wait_n), 32'd1);
        end
        repeat (extra) @(negedge clk_3m58);
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    endtask

    // loader write; ld_req is left high so successive calls run back to back
    task automatic ld_write(input logic [15:0] a, input logic [7:0] d, input logic drop);
        int n = 0;
        ld_addr = a; ld_data = d; ld_req = 1'b1;
        do begin
            @(negedge clk_3m58);
            n++;
            if (drop && ram_ce_n == 1'b0) ld_req = 1'b0;
        end while (!ld_ack && n < TIMEOUT);
        if (n >= TIMEOUT) begin
            checks++; fails++;
            $display("FAIL ld_timeout: no ld_ack for %h, required within %0d cycles", a, TIMEOUT);
        end
    endtask

    logic [15:0] pool [0:7];
    int          op, extra, a0, n;
    logic [15:0] ra;
    logic [7:0]  rd;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
            ref_mem[i] = ram_mem[i];
        end
        pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h7FFF; pool[3] = 16'h8000;
        pool[4] = 16'h8001; pool[5] = 16'hFFFF; pool[6] = 16'h1234; pool[7] = 16'hC000;

        repeat (3) @(negedge clk_3m58);
        reset = 1'b0;

        // reset held three cycles in the middle of a loader write
        @(negedge clk_3m58);
        ld_active = 1'b1;
        exp_ld(16'h4000, 8'h77);
        ld_addr = 16'h4000; ld_data = 8'h77; ld_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk_3m58);
            n++;
        end while (ram_ce_n != 1'b0 && n < 20);
        check("ld_started", 32'(ram_ce_n), 32'd0);
        reset = 1'b1; ld_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_3m58);
            check("rst_ce_n", 32'(ram_ce_n), 32'd1);
            check("rst_we_n", 32'(ram_we_n), 32'd1);
            check("rst_wait_n", 32'(cpu_wait_n), 32'd1);
            check("rst_ld_ack", 32'(ld_ack), 32'd0);
            check("rst_cpu_din", 32'(cpu_din), 32'hFF);
        end
        reset = 1'b0; ld_active = 1'b0;
        exp_q.delete();

        // read of 1234 returning A5
        @(negedge clk_3m58);
        ram_mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
        exp_rd(16'h1234);
        cpu_access(1'b1, 16'h1234, 8'h00, 0);

        // protected and unprotected writes, then read both back
        @(negedge clk_3m58); exp_wr(16'h0100, 8'h5A); cpu_access(1'b0, 16'h0100, 8'h5A, 1);
        @(negedge clk_3m58); exp_wr(16'h8000, 8'h5A); cpu_access(1'b0, 16'h8000, 8'h5A, 2);
        @(negedge clk_3m58); exp_rd(16'h0100); cpu_access(1'b1, 16'h0100, 8'h00, 0);
        @(negedge clk_3m58); exp_rd(16'h8000); cpu_access(1'b1, 16'h8000, 8'h00, 3);

        // 256 back-to-back loader writes
        @(negedge clk_3m58);
        ld_active = 1'b1;
        a0 = ack_count;
        for (int i = 0; i < 256; i++) begin
            rd = (i == 0) ? 8'h3C : 8'($urandom);
            exp_ld(16'(i), rd);
            ld_write(16'(i), rd, 1'b0);
        end
        ld_req = 1'b0;
        repeat (4) @(negedge clk_3m58);
        check("ack_count_256", 32'(ack_count - a0), 32'd256);
        ld_active = 1'b0;

        // CPU read stalled behind an active download
        @(negedge clk_3m58);
        ld_active = 1'b1;
        for (int i = 0; i < 4; i++) exp_ld(16'h2000 + 16'(i), 8'hC0 + 8'(i));
        exp_rd(16'h2002);
        fork
            begin
                for (int i = 0; i < 4; i++) ld_write(16'h2000 + 16'(i), 8'hC0 + 8'(i), 1'b0);
                ld_req = 1'b0;
                repeat (3) @(negedge clk_3m58);
                check("wait_n_stall", 32'(cpu_wait_n), 32'd0);
                ld_active = 1'b0;
            end
            begin
                @(negedge clk_3m58);
                cpu_access(1'b1, 16'h2002, 8'h00, 0);
            end
        join

        // same-cycle CPU write and loader request with no download active
        @(negedge clk_3m58);
        a0 = ack_count;
        exp_wr(16'h9000, 8'h11);
        exp_ld(16'h9001, 8'h22);
        fork
            cpu_access(1'b0, 16'h9000, 8'h11, 2);
            begin
                ld_write(16'h9001, 8'h22, 1'b0);
                ld_req = 1'b0;
            end
        join
        repeat (4) @(negedge clk_3m58);
        check("single_ld_ack", 32'(ack_count - a0), 32'd1);

        // randomized serial traffic
        for (int i = 0; i < 120; i++) begin
            op = int'($urandom_range(0, 2));
            extra = int'($urandom_range(0, 3));
            ra = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : 16'($urandom);
            rd = 8'($urandom);
            @(negedge clk_3m58);
            case (op)
                0: begin ld_active = 1'b0; exp_rd(ra); cpu_access(1'b1, ra, rd, extra); end
                1: begin ld_active = 1'b0; exp_wr(ra, rd); cpu_access(1'b0, ra, rd, extra); end
                default: begin
                    ld_active = 1'($urandom_range(0, 1));
                    exp_ld(ra, rd);
                    ld_write(ra, rd, 1'($urandom_range(0, 1)));
                    ld_req = 1'b0;
                end
            endcase
        end

        ld_active = 1'b0;
        repeat (10) @(negedge clk_3m58);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
